// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART transmitter slice: FSM state
//            encodings, frame-length constants and the standard baud divisor.
// Ports    : none (package)
// Config   : UART_TX_PARITY_EN -- adds the PARITY state and one frame bit.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 48 MHz / 417 cycles per bit ~= 115200 baud (value is bit period minus one).
  localparam int UART_DIV_115200 = 416;

  // Bits added around the data bits: start + stop, plus parity when enabled.
`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_OVERHEAD = 3;
`else
  localparam int UART_FRAME_OVERHEAD = 2;
`endif

  localparam int UART_STATE_W = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  // Total bits on the line for one frame of 'dbits' data bits.
  function automatic int uart_frame_bits(input int dbits);
    return dbits + UART_FRAME_OVERHEAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Bit-period timer. A restart loads the divisor; the counter then
//            runs down to zero, and bit_end is high while it sits at zero, so
//            each bit lasts div+1 cycles.
// Ports    : clk6x   - system clock
//            resetn  - synchronous active-low reset
//            restart - load div (start of a new bit)
//            div     - bit period minus one, sampled only on restart
//            bit_end - high in the last cycle of the current bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int DIVW = 16
) (
  input  logic            clk6x,
  input  logic            resetn,
  input  logic            restart,
  input  logic [DIVW-1:0] div,
  output logic            bit_end
);

  logic [DIVW-1:0] cnt;

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - DIVW'(1);
    end
  end

  assign bit_end = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter fed from an upstream FIFO. Sends start bit,
//            DBITS data bits LSB first, optional even parity, one stop bit.
//            Frames run back to back with no idle gap while data is available.
// Ports    : clk6x        - system clock (48 MHz)
//            resetn       - synchronous active-low reset
//            fifo_data_i  - head element of the TX FIFO
//            fifo_empty_i - TX FIFO empty flag
//            fifo_rdeq_o  - dequeue strobe (combinational, one cycle/element)
//            enable_i     - gates the start of new frames only
//            baud_div_i   - bit period minus one, sampled at each bit start
//            txd_o        - registered serial line, idle high
//            busy_o       - high while a frame is in progress
// Config   : UART_TX_PARITY_EN - define to add an even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int DIVW  = 16
) (
  input  logic             clk6x,
  input  logic             resetn,
  input  logic [DBITS-1:0] fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rdeq_o,
  input  logic             enable_i,
  input  logic [DIVW-1:0]  baud_div_i,
  output logic             txd_o,
  output logic             busy_o
);

  localparam int              CNTW     = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(DBITS - 1);

  uart_state_t      state;
  uart_state_t      state_next;
  logic [DBITS-1:0] shreg;
  logic [DBITS-1:0] shreg_next;
  logic [CNTW-1:0]  bitcnt;
  logic [CNTW-1:0]  bitcnt_next;
  logic             txd;
  logic             txd_next;
  logic             bit_end;
  logic             load;
  logic             restart;
  logic             last_data;

  // A new frame may start from IDLE or directly out of the final STOP cycle;
  // gating with resetn keeps the strobe quiet while reset is held.
  assign load = resetn && enable_i && !fifo_empty_i &&
                ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  assign fifo_rdeq_o = load;
  assign last_data   = (bitcnt == LAST_BIT);

  // Every bit boundary inside a frame reloads the timer so the divisor is
  // captured once per bit; STOP without a follow-on frame needs no reload.
  assign restart = load ||
                   (bit_end && (state != ST_IDLE) && (state != ST_STOP));

  uart_baud_cnt #(
    .DIVW (DIVW)
  ) u_baud_cnt (
    .clk6x   (clk6x),
    .resetn  (resetn),
    .restart (restart),
    .div     (baud_div_i),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers. txd is registered from the next-state decode so the
  // line changes on the same edge the FSM enters the new bit.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      shreg  <= '0;
      bitcnt <= '0;
      txd    <= 1'b1;
    end else begin
      shreg  <= shreg_next;
      bitcnt <= bitcnt_next;
      txd    <= txd_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity;

  // Even parity of the frame's data, captured together with the data.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^fifo_data_i;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    bitcnt_next = bitcnt;
    unique case (state)
      ST_IDLE: begin
        if (load) begin
          state_next = ST_START;
          shreg_next = fifo_data_i;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (last_data) begin
            bitcnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next  = ST_PARITY;
`else
            state_next  = ST_STOP;
`endif
          end else begin
            bitcnt_next = bitcnt + CNTW'(1);
            shreg_next  = shreg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (load) begin
            state_next = ST_START;
            shreg_next = fifo_data_i;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    busy_o = (state != ST_IDLE);
    unique case (state_next)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_next = parity;
`endif
      default:   txd_next = 1'b1;
    endcase
  end

  assign txd_o = txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Stimulus fills a FIFO model and
//            pushes expected frames into a scoreboard; a monitor detects each
//            start bit and checks every cycle of the frame against it.
// Config   : UART_TX_PARITY_EN - when defined, frames carry an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DBITS = 8;
  localparam int DIVW  = 16;
  localparam int NBITS = uart_frame_bits(DBITS);

  logic             clk6x        = 1'b0;
  logic             resetn       = 1'b0;
  logic [DBITS-1:0] fifo_data_i  = '0;
  logic             fifo_empty_i = 1'b1;
  logic             fifo_rdeq_o;
  logic             enable_i     = 1'b0;
  logic [DIVW-1:0]  baud_div_i   = 16'd3;
  logic             txd_o;
  logic             busy_o;

  uart_tx #(
    .DBITS (DBITS),
    .DIVW  (DIVW)
  ) dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdeq_o  (fifo_rdeq_o),
    .enable_i     (enable_i),
    .baud_div_i   (baud_div_i),
    .txd_o        (txd_o),
    .busy_o       (busy_o)
  );

  // Period is arbitrary; all checks are in cycles.
  always #10 clk6x = ~clk6x;

  typedef struct {
    logic [DBITS-1:0] data;
    int               d0;        // divisor in force for the start bit
    int               d1;        // divisor for all later bits
    int               exp_start; // cycle of first start-bit sample, -1 = any
    bit               contig;    // must follow previous frame with no gap
    bit               abort;     // frame is cut by reset; bits not checked
  } exp_t;

  exp_t             sb[$];
  logic [DBITS-1:0] fifo_q[$];
  int               checks     = 0;
  int               errors     = 0;
  int               cyc        = 0;
  int               rdeq_cnt   = 0;
  int               last_end   = -100;
  bit               mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Line image of a frame, index 0 = first bit on the wire.
  function automatic logic [15:0] frame_pat(input logic [DBITS-1:0] d);
`ifdef UART_TX_PARITY_EN
    return 16'({1'b1, ^d, d, 1'b0});
`else
    return 16'({1'b1, d, 1'b0});
`endif
  endfunction

  always @(posedge clk6x) cyc <= cyc + 1;

  // Upstream FIFO model: pops on a sampled dequeue strobe, presents head.
  always begin : fifo_model
    bit pop;
    @(negedge clk6x);
    pop = (fifo_rdeq_o === 1'b1);
    @(posedge clk6x);
    #2;
    if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  // Dequeue accounting and the never-dequeue-when-empty rule.
  always begin : rdeq_watch
    @(negedge clk6x);
    if (fifo_rdeq_o === 1'b1) begin
      rdeq_cnt++;
      if (fifo_empty_i) fail("rdeq_when_empty", $sformatf("rdeq=1 with empty=1 at cycle %0d", cyc));
    end
  end

  // Monitor: on each start bit pop the expected frame and check every cycle.
  always begin : monitor
    exp_t        e;
    logic [15:0] pat;
    int          bad;
    int          busy_bad;
    int          dur;
    bit          first;
    @(negedge clk6x);
    if (resetn && txd_o === 1'b0) begin
      if (sb.size() == 0) begin
        fail("unexpected_start", $sformatf("txd low at cycle %0d, required idle", cyc));
        for (int k = 0; k < 1000 && txd_o === 1'b0; k++) @(negedge clk6x);
      end else begin
        e = sb.pop_front();
        mon_active = 1'b1;
        if (e.exp_start >= 0) check($sformatf("start_latency_%02h", e.data), cyc, e.exp_start);
        if (e.contig) check($sformatf("frame_gap_%02h", e.data), cyc, last_end + 1);
        if (e.abort) begin
          for (int k = 0; k < 2000 && resetn; k++) @(negedge clk6x);
        end else begin
          pat      = frame_pat(e.data);
          bad      = 0;
          busy_bad = 0;
          first    = 1'b1;
          for (int b = 0; b < NBITS; b++) begin
            dur = (b == 0) ? e.d0 + 1 : e.d1 + 1;
            for (int k = 0; k < dur; k++) begin
              if (!first) @(negedge clk6x);
              first = 1'b0;
              if (txd_o !== pat[b]) bad++;
              if (busy_o !== 1'b1) busy_bad++;
            end
          end
          last_end = cyc;
          check($sformatf("frame_bits_%02h", e.data), bad, 0);
          check($sformatf("frame_busy_%02h", e.data), busy_bad, 0);
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk6x);
    #1;
  endtask

  task automatic sb_push(input logic [DBITS-1:0] d, input int d0, input int d1,
                         input int exp_start, input bit contig, input bit abort);
    exp_t e;
    e.data = d; e.d0 = d0; e.d1 = d1;
    e.exp_start = exp_start; e.contig = contig; e.abort = abort;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_active) && n < budget) begin
      @(posedge clk6x);
      n++;
    end
    if (n >= budget) fail("timeout", $sformatf("frames outstanding=%0d after %0d cycles", sb.size(), budget));
    tick(3);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int rdeq0;
    int nq;

    // Reset held with data available and enable high: nothing may move.
    tick(3);
    fifo_q.push_back(8'h5A);
    enable_i = 1'b1;
    tick(2);
    check("rst_txd", txd_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_rdeq", fifo_rdeq_o, 0);
    sb_push(8'h5A, 3, 3, -1, 1'b0, 1'b0);
    rdeq0  = rdeq_cnt;
    resetn = 1'b1;
    wait_done(200);
    check("rdeq_first", rdeq_cnt - rdeq0, 1);

    // 0xA5 at div=3: line 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit.
    baud_div_i = 16'd3;
    rdeq0 = rdeq_cnt;
    fifo_q.push_back(8'hA5);
    sb_push(8'hA5, 3, 3, cyc + 1, 1'b0, 1'b0);
    wait_done(200);
    check("rdeq_a5", rdeq_cnt - rdeq0, 1);

    // Three back-to-back frames at div=0: no idle cycle between them.
    baud_div_i = 16'd0;
    rdeq0 = rdeq_cnt;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h55);
    sb_push(8'h00, 0, 0, cyc + 1, 1'b0, 1'b0);
    sb_push(8'hFF, 0, 0, -1, 1'b1, 1'b0);
    sb_push(8'h55, 0, 0, -1, 1'b1, 1'b0);
    wait_done(200);
    check("rdeq_burst", rdeq_cnt - rdeq0, 3);
    check("fifo_drained", fifo_q.size(), 0);

    // Enable dropped in frame bit 3: frame completes, second entry stays.
    baud_div_i = 16'd1;
    rdeq0 = rdeq_cnt;
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h3C);
    sb_push(8'hC3, 1, 1, cyc + 1, 1'b0, 1'b0);
    tick(8);
    enable_i = 1'b0;
    wait_done(200);
    tick(20);
    check("dis_rdeq", rdeq_cnt - rdeq0, 1);
    check("dis_fifo_cnt", fifo_q.size(), 1);
    check("dis_busy", busy_o, 0);
    check("dis_txd", txd_o, 1);
    fifo_q.delete();
    tick(2);
    enable_i = 1'b1;

    // Reset during DATA: line idles next cycle, FIFO untouched.
    baud_div_i = 16'd3;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h99);
    sb_push(8'h3C, 3, 3, cyc + 1, 1'b0, 1'b1);
    tick(10);
    check("pre_rst_busy", busy_o, 1);
    nq       = fifo_q.size();
    rdeq0    = rdeq_cnt;
    resetn   = 1'b0;
    enable_i = 1'b0;
    tick(1);
    check("midrst_txd", txd_o, 1);
    check("midrst_busy", busy_o, 0);
    check("midrst_rdeq", fifo_rdeq_o, 0);
    tick(2);
    check("midrst_fifo_cnt", fifo_q.size(), nq);
    check("midrst_no_deq", rdeq_cnt - rdeq0, 0);
    resetn = 1'b1;
    tick(5);
    check("post_rst_txd", txd_o, 1);
    fifo_q.delete();
    tick(2);
    enable_i = 1'b1;

    // Divisor changed mid start bit: that bit keeps 417 cycles, rest use 4.
    baud_div_i = DIVW'(UART_DIV_115200);
    fifo_q.push_back(8'h0F);
    sb_push(8'h0F, UART_DIV_115200, 3, cyc + 1, 1'b0, 1'b0);
    tick(100);
    baud_div_i = 16'd3;
    wait_done(1000);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1.
    baud_div_i = 16'd1;
    fifo_q.push_back(8'h07);
    sb_push(8'h07, 1, 1, cyc + 1, 1'b0, 1'b0);
    wait_done(200);
`endif

    tick(10);
    check("sb_empty", sb.size(), 0);
    check("idle_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBITS, default 8: data bits per frame; must match the upstream FIFO element width.
REQ-002 Parameter DIVW, default 16: width of the baud divisor.
REQ-003 clk6x  input  1  system clock, 48 MHz.
REQ-004 resetn  input  1  reset: synchronous, active-low; clock clk6x.
REQ-005 fifo_data_i  input  DBITS  head element of the upstream TX FIFO; valid whenever fifo_empty_i=0.
REQ-006 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-007 fifo_rdeq_o  output  1  dequeue strobe to the upstream FIFO, one clk6x cycle per element.
REQ-008 enable_i  input  1  transmitter enable; gates only the start of new frames.
REQ-009 baud_div_i  input  DIVW  bit period minus one, in clk6x cycles.
REQ-010 txd_o  output  1  serial line, idle high, registered.
REQ-011 busy_o  output  1  high while a frame is in progress.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-013 Frame format SHALL be: start bit 0; DBITS data bits LSB first; optional parity bit; one stop bit 1.
REQ-014 Each bit SHALL last exactly baud_div_i+1 clk6x cycles, so baud_div_i=0 gives 1 cycle per bit.
REQ-015 baud_div_i SHALL be sampled at the start of each bit; a change mid-bit SHALL NOT affect the current bit.
REQ-016 Load condition: (state==IDLE, or last cycle of STOP) and enable_i=1 and fifo_empty_i=0.
REQ-017 fifo_rdeq_o SHALL be a combinational decode of the load condition, high for exactly that cycle.
REQ-018 On the clock edge where the load condition holds, fifo_data_i SHALL be latched into the shift register and the state SHALL become START.
REQ-019 txd_o SHALL go 0 in the cycle after the load edge; latency from fifo_empty_i falling (while IDLE and enabled) to the start bit SHALL be 1 cycle.
REQ-020 Back-to-back frames SHALL have no idle gap: the START of frame N+1 SHALL immediately follow the last STOP cycle of frame N.
REQ-021 In the last cycle of STOP, if the load condition is false, the next state SHALL be IDLE and txd_o SHALL stay 1.
REQ-022 enable_i=0 during a frame SHALL let the frame complete and SHALL then block further loads.
REQ-023 fifo_rdeq_o SHALL never assert while fifo_empty_i=1.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 The bit counter SHALL count DBITS data bits, then wrap to 0 on leaving DATA.

Reset
REQ-026 While resetn=0 the block SHALL hold: state IDLE, txd_o=1, busy_o=0, fifo_rdeq_o=0, counters 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, return txd_o to 1 in the next cycle, and SHALL NOT dequeue.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state is present; an even-parity bit (XOR of the data bits) is sent after DATA; frame is DBITS+3 bits.
REQ-029 Macro UART_TX_PARITY_EN undefined: no PARITY state; DATA goes directly to STOP; frame is DBITS+2 bits.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encodings, frame-length constants and UART_DIV_115200=416 (48 MHz / 417 cycles per bit).
REQ-031 The baud timer SHALL be a sub-module uart_baud_cnt: it loads baud_div_i on a restart and emits a bit-end pulse when the count reaches 0.

Verification
REQ-032 baud_div_i=3, FIFO holds 0xA5 -> txd_o pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; fifo_rdeq_o pulses once.
REQ-033 Three elements 0x00,0xFF,0x55 queued, div=0 -> 30 contiguous bit-cycles, no idle gap, 3 rdeq pulses, busy_o high throughout.
REQ-034 enable_i dropped in bit 3 of a frame with 2 elements queued -> current frame completes, second element not dequeued, busy_o falls.
REQ-035 resetn low during DATA -> next cycle txd_o=1, busy_o=0, FIFO count unchanged.
REQ-036 With UART_TX_PARITY_EN, data 0x07, div=1 -> parity bit 1, frame 11 bits of 2 cycles each.
REQ-037 baud_div_i changed from 416 to 3 mid-bit -> current bit lasts 417 cycles; next bit lasts 4 cycles.
